// File: rtl/pad_ring_pkg.sv
// Shared types and constants for the pad ring boundary-scan layer.
package pad_ring_pkg;

    typedef enum logic [1:0] {
        CmdNop     = 2'b00,
        CmdCapture = 2'b01,
        CmdShift   = 2'b10,
        CmdUpdate  = 2'b11
    } bs_cmd_t;

    typedef enum logic [1:0] {
        StIdle,
        StCapt,
        StShift,
        StUpd
    } bs_state_t;

    localparam int unsigned MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/io_sync_cell.sv
// One-bit pad input synchroniser; with PAD_FILTER_EN defined a stability filter
// follows the synchroniser so short glitches never reach the core.
module io_sync_cell #(
    parameter int unsigned SyncStages = 2
`ifdef PAD_FILTER_EN
    ,
    parameter int unsigned FiltLen = 4
`endif
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SyncStages-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], d_i};
        end
    end

`ifdef PAD_FILTER_EN
    localparam int unsigned CntW = $clog2(FiltLen + 1);

    logic            synced;
    logic            filt_q, filt_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    assign synced = sync_q[SyncStages-1];

    // Counter runs only while the synced value disagrees; any agreement restarts it.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (synced != filt_q) begin
            if (cnt_q == CntW'(FiltLen - 1)) begin
                filt_d = synced;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign q_o = filt_q;
`else
    assign q_o = sync_q[SyncStages-1];
`endif

endmodule

// File: rtl/pad_ring_bscan.sv
// Pad-to-core logic layer: synchronised/registered functional paths plus a
// capture/shift/update boundary-scan chain. Optional input filter: PAD_FILTER_EN.
module pad_ring_bscan
    import pad_ring_pkg::*;
#(
    parameter int unsigned N_IN        = 32,
    parameter int unsigned N_OUT       = 10,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4
) (
    input  logic             inClock,
    input  logic             inReset,
    input  logic [N_IN-1:0]  pad_in,
    output logic [N_IN-1:0]  core_in,
    input  logic [N_OUT-1:0] core_out,
    output logic [N_OUT-1:0] pad_out,
    input  logic             bs_mode,
    input  logic [1:0]       bs_cmd,
    input  logic             bs_cmd_valid,
    output logic             bs_cmd_ready,
    input  logic             bs_tdi,
    output logic             bs_tdo
);

    localparam int unsigned L  = N_IN + N_OUT;
    localparam int unsigned CW = $clog2(L + 1);

    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (FILT_LEN < 1) begin : g_bad_filt
        $error("FILT_LEN must be at least 1");
    end

    logic [N_IN-1:0]  synced;
    logic [L-1:0]     sr_q, upd_q;
    logic [N_OUT-1:0] pad_out_q;
    logic             mode_q;
    logic [CW-1:0]    cnt_q;
    bs_state_t        state_q, state_d;
    bs_cmd_t          cmd;
    logic             shift_last, capture_en, shift_en, update_en;

    for (genvar i = 0; i < N_IN; i++) begin : g_sync
        io_sync_cell #(
            .SyncStages(SYNC_STAGES)
`ifdef PAD_FILTER_EN
            ,
            .FiltLen(FILT_LEN)
`endif
        ) u_cell (
            .clk_i(inClock),
            .rst_i(inReset),
            .d_i  (pad_in[i]),
            .q_o  (synced[i])
        );
    end

    assign cmd        = bs_cmd_t'(bs_cmd);
    assign shift_last = (cnt_q == CW'(L - 1));

    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bs_cmd_valid) begin
                    case (cmd)
                        CmdCapture: state_d = StCapt;
                        CmdShift:   state_d = StShift;
                        CmdUpdate:  state_d = StUpd;
                        CmdNop:     state_d = StIdle;
                        default:    state_d = StIdle;
                    endcase
                end
            end
            StCapt:  state_d = StIdle;
            StShift: if (shift_last) state_d = StIdle;
            StUpd:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bs_cmd_ready = (state_q == StIdle);
        capture_en   = (state_q == StCapt);
        shift_en     = (state_q == StShift);
        update_en    = (state_q == StUpd);
    end

    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            sr_q      <= '0;
            upd_q     <= '0;
            cnt_q     <= '0;
            pad_out_q <= '0;
            mode_q    <= 1'b0;
        end else begin
            pad_out_q <= core_out;
            mode_q    <= bs_mode;
            if (capture_en) begin
                sr_q <= {core_out, synced};
            end else if (shift_en) begin
                sr_q  <= {bs_tdi, sr_q[L-1:1]};
                cnt_q <= shift_last ? '0 : cnt_q + CW'(1);
            end
            if (update_en) begin
                upd_q <= sr_q;
            end
        end
    end

    // Muxes select between registered sources, so both pad sides stay glitch-free.
    assign core_in = mode_q ? upd_q[N_IN-1:0] : synced;
    assign pad_out = mode_q ? upd_q[L-1:N_IN] : pad_out_q;
    assign bs_tdo  = sr_q[0];

endmodule

// File: tb/tb_pad_ring_bscan.sv
// Directed self-checking bench for pad_ring_bscan (N_IN=32, N_OUT=10, SYNC_STAGES=2).
module tb_pad_ring_bscan;

    localparam int unsigned NIN  = 32;
    localparam int unsigned NOUT = 10;
    localparam int unsigned L    = NIN + NOUT;
`ifdef PAD_FILTER_EN
    localparam int unsigned LAT = 6;
`else
    localparam int unsigned LAT = 2;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NIN-1:0]  pad_in = '0;
    logic [NIN-1:0]  core_in;
    logic [NOUT-1:0] core_out = '0;
    logic [NOUT-1:0] pad_out;
    logic            bs_mode = 1'b0;
    logic [1:0]      bs_cmd = 2'b00;
    logic            bs_cmd_valid = 1'b0;
    logic            bs_cmd_ready;
    logic            bs_tdi = 1'b0;
    logic            bs_tdo;

    int checks = 0;
    int errors = 0;

    pad_ring_bscan #(
        .N_IN(NIN),
        .N_OUT(NOUT),
        .SYNC_STAGES(2),
        .FILT_LEN(4)
    ) dut (
        .inClock     (clk),
        .inReset     (rst),
        .pad_in      (pad_in),
        .core_in     (core_in),
        .core_out    (core_out),
        .pad_out     (pad_out),
        .bs_mode     (bs_mode),
        .bs_cmd      (bs_cmd),
        .bs_cmd_valid(bs_cmd_valid),
        .bs_cmd_ready(bs_cmd_ready),
        .bs_tdi      (bs_tdi),
        .bs_tdo      (bs_tdo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] c);
        bs_cmd       = c;
        bs_cmd_valid = 1'b1;
        tick();
        bs_cmd_valid = 1'b0;
        bs_cmd       = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1; pad_in = '1; core_out = '1; bs_mode = 1'b1;
        repeat (3) tick();
        checks++; if (core_in !== 32'h0) begin errors++; $display("FAIL reset_core_in actual %h required 0", core_in); end
        checks++; if (pad_out !== 10'h0) begin errors++; $display("FAIL reset_pad_out actual %h required 0", pad_out); end
        checks++; if (bs_tdo !== 1'b0) begin errors++; $display("FAIL reset_tdo actual %b required 0", bs_tdo); end
        checks++; if (bs_cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready actual %b required 1", bs_cmd_ready); end
        pad_in = '0; core_out = '0; bs_mode = 1'b0; rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_functional();
        pad_in = 32'hA5A5_0F0F; core_out = 10'h2AA;
        checks++; if (pad_out !== 10'h0) begin errors++; $display("FAIL func_pad_out_c0 actual %h required 0", pad_out); end
        tick();
        checks++; if (pad_out !== 10'h2AA) begin errors++; $display("FAIL func_pad_out_c1 actual %h required 2aa", pad_out); end
        repeat (LAT - 2) tick();
        checks++; if (core_in !== 32'h0) begin errors++; $display("FAIL func_core_in_early actual %h required 0", core_in); end
        tick();
        checks++; if (core_in !== 32'hA5A5_0F0F) begin errors++; $display("FAIL func_core_in actual %h required a5a50f0f", core_in); end
        pad_in = 32'h5A5A_F0F0; core_out = 10'h0F5;
        repeat (LAT) tick();
        checks++; if (core_in !== 32'h5A5A_F0F0) begin errors++; $display("FAIL func_core_in2 actual %h required 5a5af0f0", core_in); end
        checks++; if (pad_out !== 10'h0F5) begin errors++; $display("FAIL func_pad_out2 actual %h required 0f5", pad_out); end
    endtask

    task automatic test_capture_shift();
        logic [L-1:0] exp;
        int low;
        exp = {10'h155, 32'h1234_5678};
        low = 0;
        pad_in = 32'h1234_5678; core_out = 10'h155; bs_tdi = 1'b0;
        repeat (LAT + 1) tick();
        send_cmd(2'b01);
        if (bs_cmd_ready !== 1'b1) low++;
        tick();
        checks++; if (bs_cmd_ready !== 1'b1) begin errors++; $display("FAIL capt_ready_after actual %b required 1", bs_cmd_ready); end
        send_cmd(2'b10);
        for (int i = 0; i < int'(L); i++) begin
            if (bs_cmd_ready !== 1'b1) low++;
            checks++;
            if (bs_tdo !== exp[i]) begin
                errors++; $display("FAIL shift_tdo bit %0d actual %b required %b", i, bs_tdo, exp[i]);
            end
            tick();
        end
        checks++; if (bs_cmd_ready !== 1'b1) begin errors++; $display("FAIL shift_ready_end actual %b required 1", bs_cmd_ready); end
        checks++; if (low != 43) begin errors++; $display("FAIL busy_cycles actual %0d required 43", low); end
    endtask

    task automatic test_update_mode();
        logic [L-1:0] pat;
        pat = {10'h3C3, 32'hDEAD_BEEF};
        send_cmd(2'b10);
        for (int i = 0; i < int'(L); i++) begin
            bs_tdi = pat[i];
            tick();
        end
        bs_tdi = 1'b0;
        send_cmd(2'b11);
        tick();
        checks++; if (core_in !== 32'h1234_5678) begin errors++; $display("FAIL upd_no_mode actual %h required 12345678", core_in); end
        bs_mode = 1'b1;
        checks++; if (core_in !== 32'h1234_5678) begin errors++; $display("FAIL mode_delay actual %h required 12345678", core_in); end
        tick();
        checks++; if (core_in !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mode_core_in actual %h required deadbeef", core_in); end
        checks++; if (pad_out !== 10'h3C3) begin errors++; $display("FAIL mode_pad_out actual %h required 3c3", pad_out); end
        bs_mode = 1'b0;
        tick();
        checks++; if (core_in !== 32'h1234_5678) begin errors++; $display("FAIL func_return_core_in actual %h required 12345678", core_in); end
        checks++; if (pad_out !== 10'h155) begin errors++; $display("FAIL func_return_pad_out actual %h required 155", pad_out); end
    endtask

    task automatic test_reset_mid_shift();
        bs_tdi = 1'b1;
        send_cmd(2'b10);
        repeat (20) tick();
        rst = 1'b1;
        #1;
        checks++; if (bs_cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready actual %b required 1", bs_cmd_ready); end
        checks++; if (bs_tdo !== 1'b0) begin errors++; $display("FAIL midrst_tdo actual %b required 0", bs_tdo); end
        checks++; if (core_in !== 32'h0) begin errors++; $display("FAIL midrst_core_in actual %h required 0", core_in); end
        checks++; if (pad_out !== 10'h0) begin errors++; $display("FAIL midrst_pad_out actual %h required 0", pad_out); end
        tick();
        rst = 1'b0; bs_mode = 1'b1; bs_tdi = 1'b0;
        tick();
        checks++; if (core_in !== 32'h0) begin errors++; $display("FAIL midrst_upd_core actual %h required 0", core_in); end
        checks++; if (pad_out !== 10'h0) begin errors++; $display("FAIL midrst_upd_pad actual %h required 0", pad_out); end
        send_cmd(2'b11);
        tick();
        checks++; if (core_in !== 32'h0) begin errors++; $display("FAIL post_rst_upd_core actual %h required 0", core_in); end
        checks++; if (pad_out !== 10'h0) begin errors++; $display("FAIL post_rst_upd_pad actual %h required 0", pad_out); end
    endtask

    task automatic test_busy_ignore();
        logic [L-1:0] pat;
        pat = {10'h0F0, 32'hCAFE_F00D};
        send_cmd(2'b10);
        for (int i = 0; i < int'(L); i++) begin
            bs_tdi       = pat[i];
            bs_cmd       = 2'b11;
            bs_cmd_valid = (i == 10);
            tick();
        end
        bs_cmd_valid = 1'b0; bs_cmd = 2'b00; bs_tdi = 1'b0;
        repeat (2) tick();
        checks++; if (core_in !== 32'h0) begin errors++; $display("FAIL busy_upd_core actual %h required 0", core_in); end
        checks++; if (pad_out !== 10'h0) begin errors++; $display("FAIL busy_upd_pad actual %h required 0", pad_out); end
        checks++; if (bs_cmd_ready !== 1'b1) begin errors++; $display("FAIL busy_ready actual %b required 1", bs_cmd_ready); end
        send_cmd(2'b11);
        tick();
        checks++; if (core_in !== 32'hCAFE_F00D) begin errors++; $display("FAIL real_upd_core actual %h required cafef00d", core_in); end
        checks++; if (pad_out !== 10'h0F0) begin errors++; $display("FAIL real_upd_pad actual %h required 0f0", pad_out); end
        bs_mode = 1'b0;
        tick();
    endtask

`ifdef PAD_FILTER_EN
    task automatic test_filter();
        logic seen;
        logic expb;
        pad_in = '0;
        repeat (10) tick();
        pad_in[0] = 1'b1;
        repeat (3) tick();
        pad_in[0] = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (core_in[0] !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL filt_short_pulse actual %b required 0", seen); end
        pad_in[0] = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 4) pad_in[0] = 1'b0;
            expb = (c == 6);
            checks++;
            if (core_in[0] !== expb) begin
                errors++; $display("FAIL filt_long_pulse cycle %0d actual %b required %b", c, core_in[0], expb);
            end
        end
        repeat (12) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_functional();
        test_capture_shift();
        test_update_mode();
        test_reset_mid_shift();
        test_busy_ignore();
`ifdef PAD_FILTER_EN
        test_filter();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
